// File: rtl/ft600_pkg.sv
// Shared definitions for the FT600 receive framer: FSM states and frame-format defaults.
package ft600_pkg;

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM
  } state_t;

  localparam logic [15:0] SYNC_WORD_DEF = 16'hA55A;
  localparam int          MAX_WORDS_DEF = 128;

endpackage

// File: rtl/ft600_rx_framer.sv
// Extracts SYNC/LEN/payload/CSUM frames from the FT600 word stream; payload leaves through a
// single-stage output register (1-cycle latency), in_ready only drops in PAYLOAD when that register is stalled.
module ft600_rx_framer
  import ft600_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEF,
  parameter int          MAX_WORDS = MAX_WORDS_DEF
) (
  input  logic        ftdi_clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  input  logic [1:0]  in_be,
  output logic        in_ready,
  output logic        pkt_valid,
  output logic [15:0] pkt_data,
  output logic        pkt_sof,
  output logic        pkt_eof,
  input  logic        pkt_ready,
  output logic        frame_ok,
  output logic        err_csum,
  output logic        err_len,
  output logic        err_be,
  output logic        frame_abort,
  output logic [15:0] frame_count
);

  localparam int          RW        = $clog2(MAX_WORDS + 1);
  localparam logic [15:0] MAX_LEN16 = 16'(MAX_WORDS);
  localparam logic [RW-1:0] REM_ONE = RW'(1);

  state_t        state, state_nxt;
  logic [RW-1:0] rem, rem_nxt;
  logic [15:0]   sum, sum_nxt;
  logic          first, first_nxt;
  logic          xfer, be_full, load;
  logic          ok_nxt, csum_nxt, len_nxt, be_nxt, abort_nxt;

  assign in_ready = (state == ST_PAYLOAD) ? (!pkt_valid || pkt_ready) : 1'b1;
  assign xfer     = in_valid && in_ready;
  assign be_full  = (in_be == 2'b11);

  always_ff @(posedge ftdi_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_HUNT;
      rem   <= '0;
      sum   <= '0;
      first <= 1'b0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
      sum   <= sum_nxt;
      first <= first_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    sum_nxt   = sum;
    first_nxt = first;
    load      = 1'b0;
    ok_nxt    = 1'b0;
    csum_nxt  = 1'b0;
    len_nxt   = 1'b0;
    be_nxt    = 1'b0;
    abort_nxt = 1'b0;
    case (state)
      ST_HUNT: begin
        if (xfer && be_full && in_data == SYNC_WORD) state_nxt = ST_LEN;
      end
      ST_LEN: begin
        if (xfer) begin
          if (!be_full) begin
            be_nxt    = 1'b1;
            state_nxt = ST_HUNT;
          end else if (in_data == 16'd0 || in_data > MAX_LEN16) begin
            len_nxt   = 1'b1;
            state_nxt = ST_HUNT;
          end else begin
            rem_nxt   = in_data[RW-1:0];
            sum_nxt   = '0;
            first_nxt = 1'b1;
            state_nxt = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (xfer) begin
          // A partial word kills the frame and is never forwarded.
          if (!be_full) begin
            be_nxt    = 1'b1;
            abort_nxt = 1'b1;
            state_nxt = ST_HUNT;
          end else begin
            load      = 1'b1;
            sum_nxt   = sum + in_data;
            rem_nxt   = rem - REM_ONE;
            first_nxt = 1'b0;
            if (rem == REM_ONE) state_nxt = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (xfer) begin
          if (!be_full)            be_nxt   = 1'b1;
          else if (in_data == sum) ok_nxt   = 1'b1;
          else                     csum_nxt = 1'b1;
          state_nxt = ST_HUNT;
        end
      end
      default: state_nxt = ST_HUNT;
    endcase
  end

  // Output register: a load and a drain in the same cycle keep pkt_valid high, giving 1 word/cycle.
  always_ff @(posedge ftdi_clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_valid <= 1'b0;
      pkt_data  <= '0;
      pkt_sof   <= 1'b0;
      pkt_eof   <= 1'b0;
    end else if (load) begin
      pkt_valid <= 1'b1;
      pkt_data  <= in_data;
      pkt_sof   <= first;
      pkt_eof   <= (rem == REM_ONE);
    end else if (pkt_ready) begin
      pkt_valid <= 1'b0;
    end
  end

  always_ff @(posedge ftdi_clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_ok    <= 1'b0;
      err_csum    <= 1'b0;
      err_len     <= 1'b0;
      err_be      <= 1'b0;
      frame_abort <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_ok    <= ok_nxt;
      err_csum    <= csum_nxt;
      err_len     <= len_nxt;
      err_be      <= be_nxt;
      frame_abort <= abort_nxt;
      if (ok_nxt) frame_count <= frame_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_ft600_rx_framer.sv
// Directed bench for ft600_rx_framer: vector table plus long-frame backpressure and mid-frame reset sequences.
module tb_ft600_rx_framer;

  logic        ftdi_clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic [1:0]  in_be;
  logic        in_ready;
  logic        pkt_valid;
  logic [15:0] pkt_data;
  logic        pkt_sof, pkt_eof;
  logic        pkt_ready;
  logic        frame_ok, err_csum, err_len, err_be, frame_abort;
  logic [15:0] frame_count;

  int checks = 0;
  int errors = 0;

  ft600_rx_framer dut (
    .ftdi_clk    (ftdi_clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_be       (in_be),
    .in_ready    (in_ready),
    .pkt_valid   (pkt_valid),
    .pkt_data    (pkt_data),
    .pkt_sof     (pkt_sof),
    .pkt_eof     (pkt_eof),
    .pkt_ready   (pkt_ready),
    .frame_ok    (frame_ok),
    .err_csum    (err_csum),
    .err_len     (err_len),
    .err_be      (err_be),
    .frame_abort (frame_abort),
    .frame_count (frame_count)
  );

  always #5 ftdi_clk = ~ftdi_clk;

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic [1:0]  be;
    logic        r;
    logic        pv;
    logic [15:0] pd;
    logic        sof;
    logic        eof;
    logic [4:0]  st;
    logic [15:0] cnt;
    logic        ir;
  } vec_t;

  vec_t vecs[$];

  localparam logic [4:0] S0 = 5'b00000, OK = 5'b10000, CS = 5'b01000,
                         LN = 5'b00100, BE = 5'b00010, BA = 5'b00011;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [15:0] d, input logic [1:0] be, input logic r,
                     input logic pv, input logic [15:0] pd, input logic sof, input logic eof,
                     input logic [4:0] st, input logic [15:0] cnt, input logic ir);
    vec_t x;
    x.v = v; x.d = d; x.be = be; x.r = r; x.pv = pv; x.pd = pd;
    x.sof = sof; x.eof = eof; x.st = st; x.cnt = cnt; x.ir = ir;
    vecs.push_back(x);
  endtask

  function automatic logic [4:0] status();
    return {frame_ok, err_csum, err_len, err_be, frame_abort};
  endfunction

  logic [15:0] stream[$];
  logic [15:0] wq[$];
  logic [15:0] got[$];
  logic [15:0] csum_acc;
  logic [15:0] held_d;
  logic        held, xfer, seen_ok, seen_abort;
  int          idx, rx, sofs, eofs;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_be = 2'b11; pkt_ready = 1'b1;
    #2;
    chk("reset pkt_valid", pkt_valid, 1'b0);
    chk("reset in_ready", in_ready, 1'b1);
    chk("reset frame_count", frame_count, 16'd0);
    chk("reset status", status(), S0);
    @(posedge ftdi_clk); @(posedge ftdi_clk); #1;
    rst_n = 1'b1;

    // good frame
    add(1,16'hA55A,2'b11,1, 0,16'h0,0,0,S0,16'd0,1);
    add(1,16'h0003,2'b11,1, 0,16'h0,0,0,S0,16'd0,1);
    add(1,16'h0001,2'b11,1, 1,16'h0001,1,0,S0,16'd0,1);
    add(1,16'h0002,2'b11,1, 1,16'h0002,0,0,S0,16'd0,1);
    add(1,16'h0003,2'b11,1, 1,16'h0003,0,1,S0,16'd0,1);
    add(1,16'h0006,2'b11,1, 0,16'h0,0,0,OK,16'd1,1);
    add(0,16'h0000,2'b11,1, 0,16'h0,0,0,S0,16'd1,1);
    // bad checksum: payload still forwarded
    add(1,16'hA55A,2'b11,1, 0,16'h0,0,0,S0,16'd1,1);
    add(1,16'h0003,2'b11,1, 0,16'h0,0,0,S0,16'd1,1);
    add(1,16'h0001,2'b11,1, 1,16'h0001,1,0,S0,16'd1,1);
    add(1,16'h0002,2'b11,1, 1,16'h0002,0,0,S0,16'd1,1);
    add(1,16'h0003,2'b11,1, 1,16'h0003,0,1,S0,16'd1,1);
    add(1,16'h0007,2'b11,1, 0,16'h0,0,0,CS,16'd1,1);
    // LEN = 0 and LEN = 0x81, followed by words that must be ignored in HUNT
    add(1,16'hA55A,2'b11,1, 0,16'h0,0,0,S0,16'd1,1);
    add(1,16'h0000,2'b11,1, 0,16'h0,0,0,LN,16'd1,1);
    add(1,16'h0001,2'b11,1, 0,16'h0,0,0,S0,16'd1,1);
    add(1,16'h0005,2'b11,1, 0,16'h0,0,0,S0,16'd1,1);
    add(1,16'hA55A,2'b11,1, 0,16'h0,0,0,S0,16'd1,1);
    add(1,16'h0081,2'b11,1, 0,16'h0,0,0,LN,16'd1,1);
    add(1,16'h0002,2'b11,1, 0,16'h0,0,0,S0,16'd1,1);
    add(1,16'h0007,2'b11,1, 0,16'h0,0,0,S0,16'd1,1);
    // partial SYNC word does not start a frame
    add(1,16'hA55A,2'b01,1, 0,16'h0,0,0,S0,16'd1,1);
    add(1,16'h0002,2'b11,1, 0,16'h0,0,0,S0,16'd1,1);
    add(1,16'h0009,2'b11,1, 0,16'h0,0,0,S0,16'd1,1);
    // partial word 2 of a 4-word payload
    add(1,16'hA55A,2'b11,1, 0,16'h0,0,0,S0,16'd1,1);
    add(1,16'h0004,2'b11,1, 0,16'h0,0,0,S0,16'd1,1);
    add(1,16'h0001,2'b11,1, 1,16'h0001,1,0,S0,16'd1,1);
    add(1,16'h0002,2'b01,1, 0,16'h0,0,0,BA,16'd1,1);
    add(1,16'h0003,2'b11,1, 0,16'h0,0,0,S0,16'd1,1);
    add(1,16'h0004,2'b11,1, 0,16'h0,0,0,S0,16'd1,1);
    add(1,16'h000A,2'b11,1, 0,16'h0,0,0,S0,16'd1,1);
    // partial LEN word: err_be without abort
    add(1,16'hA55A,2'b11,1, 0,16'h0,0,0,S0,16'd1,1);
    add(1,16'h0003,2'b10,1, 0,16'h0,0,0,BE,16'd1,1);
    add(1,16'h0001,2'b11,1, 0,16'h0,0,0,S0,16'd1,1);
    // SYNC value inside the payload is data
    add(1,16'hA55A,2'b11,1, 0,16'h0,0,0,S0,16'd1,1);
    add(1,16'h0002,2'b11,1, 0,16'h0,0,0,S0,16'd1,1);
    add(1,16'hA55A,2'b11,1, 1,16'hA55A,1,0,S0,16'd1,1);
    add(1,16'h0001,2'b11,1, 1,16'h0001,0,1,S0,16'd1,1);
    add(1,16'hA55B,2'b11,1, 0,16'h0,0,0,OK,16'd2,1);
    // held eof word survives the next header; in_ready drops once back in PAYLOAD
    add(1,16'hA55A,2'b11,0, 0,16'h0,0,0,S0,16'd2,1);
    add(1,16'h0001,2'b11,0, 0,16'h0,0,0,S0,16'd2,1);
    add(1,16'h0005,2'b11,0, 1,16'h0005,1,1,S0,16'd2,1);
    add(1,16'h0005,2'b11,0, 1,16'h0005,1,1,OK,16'd3,1);
    add(1,16'hA55A,2'b11,0, 1,16'h0005,1,1,S0,16'd3,1);
    add(1,16'h0001,2'b11,0, 1,16'h0005,1,1,S0,16'd3,0);
    add(1,16'h0009,2'b11,0, 1,16'h0005,1,1,S0,16'd3,0);
    add(1,16'h0009,2'b11,1, 1,16'h0009,1,1,S0,16'd3,1);
    add(1,16'h0009,2'b11,1, 0,16'h0,0,0,OK,16'd4,1);
    add(0,16'h0000,2'b11,1, 0,16'h0,0,0,S0,16'd4,1);

    for (int i = 0; i < vecs.size(); i++) begin
      in_valid = vecs[i].v; in_data = vecs[i].d; in_be = vecs[i].be; pkt_ready = vecs[i].r;
      @(posedge ftdi_clk); #1;
      chk($sformatf("v%0d pkt_valid", i), pkt_valid, vecs[i].pv);
      if (vecs[i].pv) begin
        chk($sformatf("v%0d pkt_data", i), pkt_data, vecs[i].pd);
        chk($sformatf("v%0d pkt_sof", i), pkt_sof, vecs[i].sof);
        chk($sformatf("v%0d pkt_eof", i), pkt_eof, vecs[i].eof);
      end
      chk($sformatf("v%0d status", i), status(), vecs[i].st);
      chk($sformatf("v%0d frame_count", i), frame_count, vecs[i].cnt);
      chk($sformatf("v%0d in_ready", i), in_ready, vecs[i].ir);
    end

    // 128-word frame, pkt_ready toggling every cycle
    stream.push_back(16'hA55A);
    stream.push_back(16'h0080);
    csum_acc = '0;
    for (int k = 0; k < 128; k++) begin
      wq.push_back(16'(k * 3 + 1));
      stream.push_back(16'(k * 3 + 1));
      csum_acc = csum_acc + 16'(k * 3 + 1);
    end
    stream.push_back(csum_acc);
    idx = 0; rx = 0; held = 1'b0; held_d = '0; seen_ok = 1'b0;
    for (int cyc = 0; cyc < 2000 && !(idx == 131 && rx == 128 && !pkt_valid); cyc++) begin
      pkt_ready = (cyc % 2 == 1);
      in_valid  = (idx < 131);
      in_data   = (idx < 131) ? stream[idx] : 16'h0;
      in_be     = 2'b11;
      #1;
      if (held) begin
        chk("stall pkt_valid", pkt_valid, 1'b1);
        chk("stall pkt_data", pkt_data, held_d);
      end
      if (idx >= 2 && idx <= 129)
        chk("long in_ready", in_ready, !(pkt_valid && !pkt_ready));
      if (pkt_valid && pkt_ready) begin
        if (rx < 128) begin
          chk($sformatf("long word %0d", rx), pkt_data, wq[rx]);
          chk($sformatf("long sof %0d", rx), pkt_sof, rx == 0);
          chk($sformatf("long eof %0d", rx), pkt_eof, rx == 127);
        end else begin
          chk("long extra word", rx, 128);
        end
        rx++;
      end
      held   = pkt_valid && !pkt_ready;
      held_d = pkt_data;
      xfer   = in_valid && in_ready;
      @(posedge ftdi_clk); #1;
      if (xfer) idx++;
      if (frame_ok) seen_ok = 1'b1;
    end
    chk("long words received", rx, 128);
    chk("long words sent", idx, 131);
    chk("long frame_ok", seen_ok, 1'b1);
    chk("long frame_count", frame_count, 16'd5);

    // reset mid-payload, then a clean frame
    pkt_ready = 1'b1; in_be = 2'b11;
    stream = '{16'hA55A, 16'h0004, 16'h0001, 16'h0002};
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = stream[k];
      @(posedge ftdi_clk); #1;
    end
    chk("pre-reset pkt_valid", pkt_valid, 1'b1);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst pkt_valid", pkt_valid, 1'b0);
    chk("rst pkt_data", pkt_data, 16'h0);
    chk("rst sof/eof", {pkt_sof, pkt_eof}, 2'b00);
    chk("rst status", status(), S0);
    chk("rst frame_count", frame_count, 16'd0);
    chk("rst in_ready", in_ready, 1'b1);
    @(posedge ftdi_clk); @(posedge ftdi_clk); #1;
    chk("rst hold status", status(), S0);
    rst_n = 1'b1;
    stream = '{16'hA55A, 16'h0002, 16'h0010, 16'h0020, 16'h0030};
    got.delete(); sofs = 0; eofs = 0; seen_ok = 1'b0; seen_abort = 1'b0;
    for (int k = 0; k < 8; k++) begin
      in_valid = (k < 5);
      in_data  = (k < 5) ? stream[k] : 16'h0;
      @(posedge ftdi_clk); #1;
      if (pkt_valid) begin
        got.push_back(pkt_data);
        if (pkt_sof) sofs++;
        if (pkt_eof) eofs++;
      end
      if (frame_ok) seen_ok = 1'b1;
      if (frame_abort) seen_abort = 1'b1;
    end
    chk("post-reset words", got.size(), 2);
    if (got.size() == 2) begin
      chk("post-reset word0", got[0], 16'h0010);
      chk("post-reset word1", got[1], 16'h0020);
    end
    chk("post-reset sof count", sofs, 1);
    chk("post-reset eof count", eofs, 1);
    chk("post-reset frame_ok", seen_ok, 1'b1);
    chk("post-reset no abort", seen_abort, 1'b0);
    chk("post-reset frame_count", frame_count, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ft600_rx_framer.md
FT600_RX_FRAMER -- requirements
Module: ft600_rx_framer

Interface
REQ-001 Parameter SYNC_WORD, default 16'hA55A, header word that marks the start of a frame.
REQ-002 Parameter MAX_WORDS, default 128, largest legal payload length in 16-bit words (256 B).
REQ-003 ftdi_clk  in  1  sole clock; the FT600 interface clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 in_valid  in  1  word available from the FT600 receive path.
REQ-006 in_data  in  16  received word.
REQ-007 in_be  in  2  byte enables of in_data; 2'b11 means both bytes are valid.
REQ-008 in_ready  out  1  framer accepts the word this cycle.
REQ-009 pkt_valid  out  1  payload word presented downstream.
REQ-010 pkt_data  out  16  payload word.
REQ-011 pkt_sof, pkt_eof  out  1 each  first and last payload word of a frame, qualified by pkt_valid.
REQ-012 pkt_ready  in  1  downstream accepts the payload word.
REQ-013 frame_ok, err_csum, err_len, err_be, frame_abort  out  1 each  single-cycle status pulses.
REQ-014 frame_count  out  16  count of good frames; wraps modulo 2^16.

Function
REQ-015 The frame format SHALL be SYNC_WORD, then LEN (1..MAX_WORDS), then LEN payload words, then CSUM, where CSUM is the sum of the payload words modulo 2^16.
REQ-016 The FSM SHALL have four states: HUNT, LEN, PAYLOAD, CSUM; the reset state SHALL be HUNT.
REQ-017 A transfer SHALL occur only when in_valid and in_ready are both high in the same cycle.
REQ-018 HUNT: a transfer of SYNC_WORD with in_be=2'b11 SHALL move the FSM to LEN; every other word SHALL be silently discarded.
REQ-019 LEN: a LEN of 0 or greater than MAX_WORDS SHALL pulse err_len and return to HUNT; otherwise the FSM SHALL latch LEN, clear the running sum and enter PAYLOAD.
REQ-020 PAYLOAD: each transfer SHALL load the output register, add the word to the sum and decrement the remaining count.
  - pkt_sof SHALL be high on the first payload word; pkt_eof SHALL be high on the last.
  - After the last word the FSM SHALL enter CSUM.
REQ-021 CSUM: on a match, frame_ok SHALL pulse and frame_count SHALL increment; on a mismatch, err_csum SHALL pulse. Either case SHALL return to HUNT.
REQ-022 In LEN, PAYLOAD and CSUM, a transfer with in_be!=2'b11 SHALL pulse err_be and return to HUNT.
REQ-023 If that partial word arrives in PAYLOAD, frame_abort SHALL also pulse, no further pkt_valid SHALL occur for the frame, and the word SHALL NOT be forwarded.
REQ-024 The output register SHALL be a single stage, so payload latency is exactly 1 cycle from transfer to pkt_valid.
REQ-025 in_ready SHALL equal (!pkt_valid || pkt_ready) in PAYLOAD, and 1 in all other states.
REQ-026 pkt_valid SHALL stay high with pkt_data, pkt_sof and pkt_eof stable until pkt_ready is high.
REQ-027 Simultaneous output drain and new load in the same cycle SHALL sustain 1 word/cycle with no bubble.
REQ-028 A pending final word (pkt_eof) MAY still be held while the FSM is in CSUM or HUNT; accepting the next frame's header SHALL NOT disturb it.
REQ-029 A SYNC_WORD value occurring inside the payload SHALL be treated as data and SHALL NOT resynchronise the FSM.
REQ-030 All status pulses SHALL be registered and last exactly one cycle.

Reset
REQ-031 Asserting rst_n low SHALL immediately force state HUNT and drive pkt_valid, pkt_sof, pkt_eof and all status pulses to 0.
REQ-032 Reset SHALL also clear pkt_data, frame_count, the sum and the remaining count to 0.
REQ-033 in_ready SHALL read 1 during reset.
REQ-034 Reset asserted mid-frame SHALL discard the frame with no frame_abort pulse; after release the framer SHALL hunt for a new SYNC_WORD.

Structure
REQ-035 The state enum, the SYNC_WORD default and the MAX_WORDS default SHALL live in a shared package, ft600_pkg.
REQ-036 The block SHALL be a single module with no sub-modules; the 1-deep output register SHALL be inline.

Verification
REQ-037 Scenario: input A55A, 0003, 0001, 0002, 0003, 0006 with pkt_ready=1.
  - Required: payload 0001/0002/0003 with sof on the first word and eof on the last.
  - Required: frame_ok pulses and frame_count becomes 1.
REQ-038 Scenario: the same frame with CSUM=0007.
  - Required: payload still forwarded, err_csum pulses, frame_count is unchanged.
REQ-039 Scenario: LEN=0000 and, separately, LEN=0081 with MAX_WORDS=128.
  - Required: err_len pulses, no pkt_valid, and the FSM is back in HUNT.
REQ-040 Scenario: 128-word frame with pkt_ready toggling every cycle.
  - Required: no word lost or duplicated, and pkt_data is stable while stalled.
  - Required: in_ready drops exactly when pkt_valid && !pkt_ready.
REQ-041 Scenario: word 2 of a 4-word payload has in_be=2'b01.
  - Required: err_be and frame_abort pulse, only word 1 is emitted, and no eof is emitted.
REQ-042 Scenario: rst_n pulsed low mid-payload, then a valid frame is sent.
  - Required: outputs are 0 during reset, and the following frame is received intact.
